// File: rtl/ddr_pin_pkg.sv
// Shared types and defaults for the DDR pin burst controller.
package ddr_pin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_WAIT,
    ST_TURN
  } state_e;

  localparam int unsigned WORD_W_DEF   = 8;
  localparam int unsigned PRE_CYC_DEF  = 2;
  localparam int unsigned TURN_CYC_DEF = 2;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : unsigned'($clog2(n));
  endfunction

  localparam int unsigned BEAT_W = cnt_w(WORD_W_DEF / 2);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the served requester on i_done.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_done_id,
  output logic [1:0] o_gnt_c
);

  // Requester served most recently; resets to 1 so requester 0 wins the first tie.
  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_done) begin
      r_last <= i_done_id;
    end
  end

  always_comb begin
    o_gnt_c = i_req;
    if (i_req == 2'b11) begin
      o_gnt_c = r_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ddr_pin_burst_ctrl.sv
// Shares one ODDRE1+IOBUF pad between two requesters, framing each burst with
// a driven-low preamble and a hi-Z turnaround.
module ddr_pin_burst_ctrl
  import ddr_pin_pkg::*;
#(
  parameter int unsigned WORD_W   = WORD_W_DEF,
  parameter int unsigned PRE_CYC  = PRE_CYC_DEF,
  parameter int unsigned TURN_CYC = TURN_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_last,
  input  logic [2*WORD_W-1:0] req_data,
  output logic [1:0]          req_ready,
  output logic                oddr_d1,
  output logic                oddr_d2,
  output logic                iobuf_t,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int unsigned BEATS   = WORD_W / 2;
  localparam int unsigned BCW     = cnt_w(BEATS);
  localparam int unsigned CNT_MAX = (PRE_CYC > TURN_CYC) ? PRE_CYC : TURN_CYC;
  localparam int unsigned CW      = cnt_w(CNT_MAX);

  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
  localparam logic [CW-1:0]  PRE_LAST  = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0]  TURN_LAST = CW'(TURN_CYC - 1);

  state_e            r_state;
  logic [1:0]        r_grant;
  logic [CW-1:0]     r_cnt;
  logic [BCW-1:0]    r_beat;
  logic [WORD_W-1:0] r_sh;
  logic              r_last_acc;
  logic              r_d1;
  logic              r_d2;
  logic              r_t;
  logic              r_busy;

  logic [1:0]        w_arb_gnt;
  logic [1:0]        w_rdy;
  logic              w_acc;
  logic              w_done;
  logic              w_last;
  logic [WORD_W-1:0] w_data;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req_valid),
    .i_done    (w_done),
    .i_done_id (r_grant[1]),
    .o_gnt_c   (w_arb_gnt)
  );

  // Ready windows: last PRE cycle, last beat of a non-final word, and underrun.
  always_comb begin
    w_rdy = 2'b00;
    case (r_state)
      ST_PRE:   if (r_cnt == PRE_LAST) w_rdy = r_grant;
      ST_SHIFT: if ((r_beat == BEAT_LAST) && !r_last_acc) w_rdy = r_grant;
      ST_WAIT:  w_rdy = r_grant;
      default:  w_rdy = 2'b00;
    endcase
  end

  assign w_acc  = |(req_valid & w_rdy);
  assign w_data = r_grant[1] ? req_data[2*WORD_W-1:WORD_W] : req_data[WORD_W-1:0];
  assign w_last = r_grant[1] ? req_last[1] : req_last[0];
  assign w_done = (r_state == ST_TURN) && (r_cnt == TURN_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_sh       <= '0;
      r_last_acc <= 1'b0;
      r_d1       <= 1'b0;
      r_d2       <= 1'b0;
      r_t        <= 1'b1;
      r_busy     <= 1'b0;
    end else if (w_acc) begin
      // Every accept starts a new word with beat 0 on the pins next cycle.
      r_state    <= ST_SHIFT;
      r_beat     <= '0;
      r_d1       <= w_data[0];
      r_d2       <= w_data[1];
      r_sh       <= w_data >> 2;
      r_last_acc <= w_last;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_state    <= ST_PRE;
            r_grant    <= w_arb_gnt;
            r_cnt      <= '0;
            r_last_acc <= 1'b0;
            r_t        <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_PRE: begin
          if (r_cnt != PRE_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_SHIFT: begin
          if (r_beat != BEAT_LAST) begin
            r_beat <= r_beat + BCW'(1);
            r_d1   <= r_sh[0];
            r_d2   <= r_sh[1];
            r_sh   <= r_sh >> 2;
          end else if (r_last_acc) begin
            r_state <= ST_TURN;
            r_cnt   <= '0;
            r_t     <= 1'b1;
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
          end else begin
            r_state <= ST_WAIT;
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_d1 <= 1'b0;
          r_d2 <= 1'b0;
        end
        ST_TURN: begin
          if (r_cnt != TURN_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_rdy;
  assign oddr_d1   = r_d1;
  assign oddr_d2   = r_d2;
  assign iobuf_t   = r_t;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule
